// File: rtl/st2110_eth_pkg.sv
// rtl/st2110_eth_pkg.sv - shared Ethernet framing constants, rx state enum and MAC helper
package st2110_eth_pkg;

  localparam int          ETH_HDR_BEATS  = 7;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [47:0] BROADCAST_MAC  = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DROP
  } rx_state_t;

  // Beat idx 0..2 of a MAC address as it appears on the 16-bit wire, first byte in [15:8]
  function automatic logic [15:0] mac_word(input logic [47:0] mac, input logic [2:0] idx);
    case (idx)
      3'd0:    mac_word = mac[47:32];
      3'd1:    mac_word = mac[31:16];
      default: mac_word = mac[15:0];
    endcase
  endfunction

endpackage

// File: rtl/ethernet_rx_if.sv
// rtl/ethernet_rx_if.sv - wire-side beat stream in, RTP payload stream out
interface ethernet_rx_if;

  logic [15:0] eth_rx_data;
  logic        eth_rx_valid;
  logic        eth_rx_sop;
  logic        eth_rx_eop;

  logic [15:0] rtp_data;
  logic        rtp_valid;
  logic        rtp_sop;
  logic        rtp_eop;
  logic        rtp_err;

  modport master (
    output eth_rx_data, eth_rx_valid, eth_rx_sop, eth_rx_eop,
    input  rtp_data, rtp_valid, rtp_sop, rtp_eop, rtp_err
  );

  modport slave (
    input  eth_rx_data, eth_rx_valid, eth_rx_sop, eth_rx_eop,
    output rtp_data, rtp_valid, rtp_sop, rtp_eop, rtp_err
  );

endinterface

// File: rtl/st2110_sat_cnt.sv
// rtl/st2110_sat_cnt.sv - 16-bit saturating incrementer with synchronous load
module st2110_sat_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'h0000;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != 16'hFFFF)) begin
      count <= count + 16'h0001;
    end
  end

endmodule

// File: rtl/ethernet_rx.sv
// rtl/ethernet_rx.sv - Ethernet header filter: forwards matching payload beats, counts frames
module ethernet_rx
  import st2110_eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC         = 48'h02_00_00_00_00_01,
  parameter logic [15:0] ETHERTYPE         = ETHERTYPE_IPV4,
  parameter int          MAX_PAYLOAD_BEATS = 750
) (
  input  logic             clk,
  input  logic             rst_n,
  ethernet_rx_if.slave     bus,
  output logic [47:0]      rx_src_mac,
  output logic [15:0]      frames_ok,
  output logic [15:0]      frames_dropped
);

  localparam int             PW       = $clog2(MAX_PAYLOAD_BEATS + 1);
  localparam logic [2:0]     LAST_HDR = 3'(ETH_HDR_BEATS - 1);
  localparam logic [PW-1:0]  LAST_PAY = PW'(MAX_PAYLOAD_BEATS - 1);

  rx_state_t      state, state_n;
  logic [2:0]     beat_cnt, beat_n;
  logic           uc_miss, uc_miss_n, bc_miss, bc_miss_n;
  logic [PW-1:0]  pay_cnt, pay_n;
  logic           first_pay, first_n;
  logic [47:0]    src_shadow, src_n, mac_n;
  logic [15:0]    data_q, data_n;
  logic           valid_q, valid_n, sop_q, sop_n, eop_q, eop_n, err_q, err_n;
  logic           ok_inc, drop_inc;
  logic [2:0]     hdr_idx;
  logic           uc_cur, bc_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beat_cnt   <= 3'd0;
      uc_miss    <= 1'b0;
      bc_miss    <= 1'b0;
      pay_cnt    <= '0;
      first_pay  <= 1'b0;
      src_shadow <= 48'h0;
      rx_src_mac <= 48'h0;
      data_q     <= 16'h0;
      valid_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      beat_cnt   <= beat_n;
      uc_miss    <= uc_miss_n;
      bc_miss    <= bc_miss_n;
      pay_cnt    <= pay_n;
      first_pay  <= first_n;
      src_shadow <= src_n;
      rx_src_mac <= mac_n;
      data_q     <= data_n;
      valid_q    <= valid_n;
      sop_q      <= sop_n;
      eop_q      <= eop_n;
      err_q      <= err_n;
    end
  end

  // Any sop restarts header parsing at beat 0, whatever state it arrives in
  assign hdr_idx = bus.eth_rx_sop ? 3'd0 : beat_cnt;
  assign uc_cur  = bus.eth_rx_sop ? 1'b0 : uc_miss;
  assign bc_cur  = bus.eth_rx_sop ? 1'b0 : bc_miss;

  always_comb begin
    state_n   = state;
    beat_n    = beat_cnt;
    uc_miss_n = uc_miss;
    bc_miss_n = bc_miss;
    pay_n     = pay_cnt;
    first_n   = first_pay;
    src_n     = src_shadow;
    mac_n     = rx_src_mac;
    data_n    = data_q;
    valid_n   = 1'b0;
    sop_n     = 1'b0;
    eop_n     = 1'b0;
    err_n     = 1'b0;
    ok_inc    = 1'b0;
    drop_inc  = 1'b0;

    if (bus.eth_rx_valid) begin
      if (bus.eth_rx_sop || (state == HDR)) begin
        if (bus.eth_rx_sop && (state == PAYLOAD)) begin
          data_n   = 16'h0;
          valid_n  = 1'b1;
          eop_n    = 1'b1;
          err_n    = 1'b1;
          drop_inc = 1'b1;
        end
        if (bus.eth_rx_sop && (state == HDR)) begin
          drop_inc = 1'b1;
        end
        state_n   = HDR;
        beat_n    = hdr_idx + 3'd1;
        uc_miss_n = uc_cur;
        bc_miss_n = bc_cur;
        // Unicast and broadcast are tracked separately so a mixed address never matches
        if (hdr_idx < 3'd3) begin
          uc_miss_n = uc_cur | (bus.eth_rx_data != mac_word(LOCAL_MAC, hdr_idx));
          bc_miss_n = bc_cur | (bus.eth_rx_data != mac_word(BROADCAST_MAC, hdr_idx));
        end
        case (hdr_idx)
          3'd3:    src_n[47:32] = bus.eth_rx_data;
          3'd4:    src_n[31:16] = bus.eth_rx_data;
          3'd5:    src_n[15:0]  = bus.eth_rx_data;
          default: ;
        endcase
        if (bus.eth_rx_eop) begin
          state_n  = IDLE;
          drop_inc = 1'b1;
        end else if (hdr_idx == LAST_HDR) begin
          if (!(uc_miss_n && bc_miss_n) && (bus.eth_rx_data == ETHERTYPE)) begin
            state_n = PAYLOAD;
            mac_n   = src_n;
            pay_n   = '0;
            first_n = 1'b1;
          end else begin
            state_n  = DROP;
            drop_inc = 1'b1;
          end
        end
      end else begin
        case (state)
          PAYLOAD: begin
            valid_n = 1'b1;
            data_n  = bus.eth_rx_data;
            sop_n   = first_pay;
            first_n = 1'b0;
            pay_n   = pay_cnt + 1'b1;
            if (bus.eth_rx_eop) begin
              eop_n   = 1'b1;
              ok_inc  = 1'b1;
              state_n = IDLE;
            end else if (pay_cnt == LAST_PAY) begin
              eop_n    = 1'b1;
              err_n    = 1'b1;
              drop_inc = 1'b1;
              state_n  = DROP;
            end
          end
          DROP: begin
            if (bus.eth_rx_eop) begin
              state_n = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rtp_data  = data_q;
  assign bus.rtp_valid = valid_q;
  assign bus.rtp_sop   = sop_q;
  assign bus.rtp_eop   = eop_q;
  assign bus.rtp_err   = err_q;

  st2110_sat_cnt u_ok_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val (16'h0000),
    .inc      (ok_inc),
    .count    (frames_ok)
  );

  st2110_sat_cnt u_drop_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (1'b0),
    .load_val (16'h0000),
    .inc      (drop_inc),
    .count    (frames_dropped)
  );

endmodule
